input_layer_compute: RTL and testbench
======================================

Name: input_layer_compute

Overview:
- Executes the input (first fully-connected) layer of the DNN datapath when the scheduler issues `input_compute_start`.
- For each output neuron it computes bias + Σ(x[i]·w[j][i]), then applies fixed-point rescale, optional ReLU and saturation.
- Each result is written to the layer output buffer.
- Pulses `input_compute_done` to the scheduler when all neurons are written.
- Input, weight and bias memories are external synchronous-read RAMs with 1-cycle read latency.

Parameters:
- DATA_W, 8: signed width of inputs, weights, biases, outputs (two's complement).
- N_IN, 16: input vector length, ≥2.
- N_OUT, 8: number of output neurons, ≥1.
- ACC_W, 24: signed accumulator width.
- FRAC_BITS, 4: fractional bits of the DATA_W fixed-point format.
- RELU, 1: 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- input_compute_start  input  1  start request from scheduler; sampled only in IDLE.
- input_compute_done  output  1  one-cycle completion pulse to scheduler.
- busy  output  1  high in every non-IDLE state.
- in_rd_en  output  1  input RAM read enable.
- in_addr  output  clog2(N_IN)  input RAM address.
- in_data  input  DATA_W  input RAM data, valid the cycle after in_rd_en.
- w_rd_en  output  1  weight RAM read enable.
- w_addr  output  clog2(N_IN*N_OUT)  weight RAM address, = j*N_IN+i.
- w_data  input  DATA_W  weight data, 1-cycle latency.
- b_rd_en  output  1  bias RAM read enable.
- b_addr  output  clog2(N_OUT)  bias RAM address.
- b_data  input  DATA_W  bias data, 1-cycle latency.
- out_wr_en  output  1  output buffer write strobe.
- out_addr  output  clog2(N_OUT)  output neuron index.
- out_data  output  DATA_W  neuron result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: done, busy, all enables, addresses, out_data.
  - Accumulator and counters cleared.
- States: IDLE, BIAS, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - input_compute_start=1 → BIAS, neuron j=0.
  - Otherwise stay in IDLE.
- BIAS (1 cycle):
  - b_rd_en=1, b_addr=j.
  - → MAC with i=0.
- MAC (N_IN cycles):
  - in_rd_en=w_rd_en=1, in_addr=i, w_addr=j*N_IN+i, i increments each cycle.
  - First MAC cycle: acc ← sign_ext(b_data) << FRAC_BITS.
  - Later MAC cycles: acc ← acc + in_data*w_data (product of data issued the previous cycle).
  - After i=N_IN-1 is issued → DRAIN.
- DRAIN (1 cycle):
  - Accumulates the last product.
  - All read enables 0.
  - → WRITE.
- WRITE (1 cycle):
  - out_wr_en=1, out_addr=j, out_data=f(acc).
  - j<N_OUT-1 → j++, → BIAS.
  - Otherwise → DONE.
- DONE (1 cycle):
  - input_compute_done=1.
  - → IDLE.
- Arithmetic:
  - Products are full 2·DATA_W signed, sign-extended to ACC_W.
  - Accumulator wraps modulo 2^ACC_W, no internal saturation.
  - f(acc) = s = acc >>> FRAC_BITS (arithmetic shift).
  - If RELU=1 and s<0 → 0.
  - Otherwise saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Latency:
  - Per neuron: N_IN+3 cycles.
  - input_compute_done asserts exactly N_OUT*(N_IN+3)+1 cycles after the cycle start was sampled in IDLE (153 at defaults).
- Start rules:
  - input_compute_start is ignored in every state except IDLE, including during DONE.
  - A start held high continuously causes back-to-back runs: the next run begins the cycle after DONE.
- Read enables and out_wr_en are never high in the same cycle.
- Reset mid-run:
  - Immediate return to IDLE.
  - No done pulse and no further writes.
  - Partial output buffer contents are left as written.
- Outputs are registered; out_data holds its last value when out_wr_en=0.

Test Plan:
- Reset with reset=0 for 3 cycles, start toggling → all outputs 0, busy=0, no RAM enables.
- x[i]=16, w=2 for all, bias=0 → 8 writes with out_data=32, out_addr 0..7 in order, one write every 19 cycles; done exactly 153 cycles after start, for one cycle.
- w=−2 for all, bias[3]=5 with w[3][*]=0:
  - RELU=1 → neurons ≠3 output 0, neuron 3 outputs 5.
  - RELU=0 → neurons ≠3 output −32.
- x=127, w=127 → s=16129 → out_data=127 for every neuron.
- x=−128, w=127, RELU=0 → out_data=−128.
- Start pulsed again at cycle 40 and held high 10 cycles mid-run → exactly one done pulse at cycle 153, 8 writes total.
- Start held high permanently → second run begins at cycle 154 and completes identically.
- reset=0 during neuron 3 MAC → busy=0 and out_wr_en=0 immediately, no done pulse; a following start yields full correct 8-neuron results and done at +153.

Source files
------------

// File: rtl/input_layer_compute_if.sv
// Bus bundle for input_layer_compute.
// Groups the scheduler handshake, the three synchronous-read RAM ports (input, weight,
// bias) and the output buffer write port.
//   master : the compute block (drives enables, addresses, results, done/busy)
//   slave  : the environment (scheduler + RAMs + output buffer)
interface input_layer_compute_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_IN   = 16,
   parameter int unsigned N_OUT  = 8
);
   localparam int unsigned InAw  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned WAw   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
   localparam int unsigned OutAw = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   // Scheduler handshake
   logic                     input_compute_start;
   logic                     input_compute_done;
   logic                     busy;
   // Input RAM
   logic                     in_rd_en;
   logic [InAw-1:0]          in_addr;
   logic signed [DATA_W-1:0] in_data;
   // Weight RAM
   logic                     w_rd_en;
   logic [WAw-1:0]           w_addr;
   logic signed [DATA_W-1:0] w_data;
   // Bias RAM
   logic                     b_rd_en;
   logic [OutAw-1:0]         b_addr;
   logic signed [DATA_W-1:0] b_data;
   // Output buffer
   logic                     out_wr_en;
   logic [OutAw-1:0]         out_addr;
   logic signed [DATA_W-1:0] out_data;

   modport master (
      input  input_compute_start, in_data, w_data, b_data,
      output input_compute_done, busy,
      output in_rd_en, in_addr, w_rd_en, w_addr, b_rd_en, b_addr,
      output out_wr_en, out_addr, out_data
   );

   modport slave (
      output input_compute_start, in_data, w_data, b_data,
      input  input_compute_done, busy,
      input  in_rd_en, in_addr, w_rd_en, w_addr, b_rd_en, b_addr,
      input  out_wr_en, out_addr, out_data
   );
endinterface

// File: rtl/input_layer_compute.sv
// Input (first fully-connected) layer of the DNN datapath.
// On a start request from the scheduler, for every output neuron j it computes
//   acc = (bias[j] << FRAC_BITS) + sum_i x[i] * w[j*N_IN + i]
// then rescales (acc >>> FRAC_BITS), applies optional ReLU, saturates to DATA_W and writes
// the result to the output buffer. A one-cycle done pulse follows the last write.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : master side of input_layer_compute_if (handshake, RAM reads, output writes)
// All outputs are registered; they are computed from the next state so that each
// enable/address is valid in the same cycle as the state it belongs to.
module input_layer_compute #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_IN      = 16,
   parameter int unsigned N_OUT     = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned FRAC_BITS = 4,
   parameter bit          RELU      = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   input_layer_compute_if.master bus
);

   localparam int unsigned InAw  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned WAw   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
   localparam int unsigned OutAw = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic [InAw-1:0]  LastI = InAw'(N_IN - 1);
   localparam logic [OutAw-1:0] LastJ = OutAw'(N_OUT - 1);

   localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

   typedef enum logic [2:0] {
      StIdle,
      StBias,
      StMac,
      StDrain,
      StWrite,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [InAw-1:0]          i_q, i_d;
   logic [OutAw-1:0]         j_q, j_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   logic                     done_q, done_d;
   logic                     busy_q, busy_d;
   logic                     in_rd_en_q, in_rd_en_d;
   logic [InAw-1:0]          in_addr_q, in_addr_d;
   logic                     w_rd_en_q, w_rd_en_d;
   logic [WAw-1:0]           w_addr_q, w_addr_d;
   logic                     b_rd_en_q, b_rd_en_d;
   logic [OutAw-1:0]         b_addr_q, b_addr_d;
   logic                     out_wr_en_q, out_wr_en_d;
   logic [OutAw-1:0]         out_addr_q, out_addr_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;

   // Full-precision product of the data returned for the previous cycle's read.
   assign prod     = bus.in_data * bus.w_data;
   assign prod_ext = ACC_W'(prod);
   assign bias_ext = ACC_W'(bus.b_data);

   // Rescale, optional ReLU, then saturate to the DATA_W range.
   function automatic logic signed [DATA_W-1:0] rescale(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] s;
      s = acc >>> FRAC_BITS;
      if (RELU && s[ACC_W-1]) begin
         return '0;
      end else if (s > SatMax) begin
         return SatMax[DATA_W-1:0];
      end else if (s < SatMin) begin
         return SatMin[DATA_W-1:0];
      end
      return s[DATA_W-1:0];
   endfunction

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         i_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         in_rd_en_q  <= 1'b0;
         in_addr_q   <= '0;
         w_rd_en_q   <= 1'b0;
         w_addr_q    <= '0;
         b_rd_en_q   <= 1'b0;
         b_addr_q    <= '0;
         out_wr_en_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         in_rd_en_q  <= in_rd_en_d;
         in_addr_q   <= in_addr_d;
         w_rd_en_q   <= w_rd_en_d;
         w_addr_q    <= w_addr_d;
         b_rd_en_q   <= b_rd_en_d;
         b_addr_q    <= b_addr_d;
         out_wr_en_q <= out_wr_en_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.input_compute_start) state_d = StBias;
         StBias:  state_d = StMac;
         StMac:   if (i_q == LastI) state_d = StDrain;
         StDrain: state_d = StWrite;
         StWrite: state_d = (j_q == LastJ) ? StDone : StBias;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Counters, accumulator and next values of the registered outputs
   always_comb begin
      i_d   = i_q;
      j_d   = j_q;
      acc_d = acc_q;

      case (state_q)
         StIdle: begin
            if (bus.input_compute_start) j_d = '0;
         end
         StBias: begin
            i_d = '0;
         end
         StMac: begin
            if (i_q != LastI) i_d = i_q + 1'b1;
            // The bias read issued in StBias returns during the first MAC cycle.
            if (i_q == '0) begin
               acc_d = bias_ext <<< FRAC_BITS;
            end else begin
               acc_d = acc_q + prod_ext;
            end
         end
         StDrain: begin
            acc_d = acc_q + prod_ext;
         end
         StWrite: begin
            if (j_q != LastJ) j_d = j_q + 1'b1;
         end
         default: ;
      endcase

      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      b_rd_en_d   = (state_d == StBias);
      in_rd_en_d  = (state_d == StMac);
      w_rd_en_d   = (state_d == StMac);
      out_wr_en_d = (state_d == StWrite);

      // Addresses and result hold their last value while not in use.
      b_addr_d   = b_rd_en_d ? j_d : b_addr_q;
      in_addr_d  = in_rd_en_d ? i_d : in_addr_q;
      w_addr_d   = w_rd_en_d ? (WAw'(j_d) * WAw'(N_IN) + WAw'(i_d)) : w_addr_q;
      out_addr_d = out_wr_en_d ? j_d : out_addr_q;
      out_data_d = out_wr_en_d ? rescale(acc_d) : out_data_q;
   end

   assign bus.input_compute_done = done_q;
   assign bus.busy               = busy_q;
   assign bus.in_rd_en           = in_rd_en_q;
   assign bus.in_addr            = in_addr_q;
   assign bus.w_rd_en            = w_rd_en_q;
   assign bus.w_addr             = w_addr_q;
   assign bus.b_rd_en            = b_rd_en_q;
   assign bus.b_addr             = b_addr_q;
   assign bus.out_wr_en          = out_wr_en_q;
   assign bus.out_addr           = out_addr_q;
   assign bus.out_data           = out_data_q;

endmodule

// File: tb/tb_input_layer_compute.sv
// Bench for input_layer_compute: two instances (RELU=1 and RELU=0) share one stimulus
// stream and identical RAM contents. Issuing a run pushes the expected writes and done
// time into per-instance queues; a negedge monitor pops and compares.
module tb_input_layer_compute;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned N_IN      = 16;
   localparam int unsigned N_OUT     = 8;
   localparam int unsigned ACC_W     = 24;
   localparam int unsigned FRAC_BITS = 4;
   localparam int NeuronCyc = N_IN + 3;
   localparam int RunCyc    = N_OUT * NeuronCyc + 1;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic signed [DATA_W-1:0] x_mem [N_IN];
   logic signed [DATA_W-1:0] w_mem [N_IN*N_OUT];
   logic signed [DATA_W-1:0] b_mem [N_OUT];

   wr_t exp_q  [2][$];
   int  done_q [2][$];

   input_layer_compute_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) bus_r ();
   input_layer_compute_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) bus_n ();

   input_layer_compute #(
      .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W),
      .FRAC_BITS(FRAC_BITS), .RELU(1'b1)
   ) dut_r (
      .clk(clk), .reset(reset), .bus(bus_r.master)
   );

   input_layer_compute #(
      .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W),
      .FRAC_BITS(FRAC_BITS), .RELU(1'b0)
   ) dut_n (
      .clk(clk), .reset(reset), .bus(bus_n.master)
   );

   assign bus_r.input_compute_start = start;
   assign bus_n.input_compute_start = start;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAMs, one cycle latency
   always @(posedge clk) begin
      if (bus_r.in_rd_en) bus_r.in_data <= x_mem[bus_r.in_addr];
      if (bus_r.w_rd_en)  bus_r.w_data  <= w_mem[bus_r.w_addr];
      if (bus_r.b_rd_en)  bus_r.b_data  <= b_mem[bus_r.b_addr];
      if (bus_n.in_rd_en) bus_n.in_data <= x_mem[bus_n.in_addr];
      if (bus_n.w_rd_en)  bus_n.w_data  <= w_mem[bus_n.w_addr];
      if (bus_n.b_rd_en)  bus_n.b_data  <= b_mem[bus_n.b_addr];
   end

   // Reference: exact integer dot product, wrapped to ACC_W, floor-divided by 2^FRAC_BITS
   function automatic int ref_out(int j, bit relu);
      longint acc, s, full, half, scale;
      full  = longint'(1) << ACC_W;
      half  = full / 2;
      scale = longint'(1) << FRAC_BITS;
      acc = longint'(b_mem[j]) * scale;
      for (int i = 0; i < N_IN; i++) begin
         acc += longint'(x_mem[i]) * longint'(w_mem[j*N_IN + i]);
      end
      acc = acc % full;
      if (acc >= half) acc -= full;
      if (acc < -half) acc += full;
      s = acc / scale;
      if (acc < 0 && (acc % scale) != 0) s -= 1;
      if (relu && s < 0) return 0;
      if (s > 127) return 127;
      if (s < -128) return -128;
      return int'(s);
   endfunction

   task automatic push_run(int s);
      wr_t e;
      for (int j = 0; j < N_OUT; j++) begin
         e.cyc  = s + NeuronCyc * (j + 1);
         e.addr = j;
         e.data = ref_out(j, 1'b1);
         exp_q[0].push_back(e);
         e.data = ref_out(j, 1'b0);
         exp_q[1].push_back(e);
      end
      done_q[0].push_back(s + RunCyc);
      done_q[1].push_back(s + RunCyc);
   endtask

   task automatic flush();
      for (int k = 0; k < 2; k++) begin
         exp_q[k].delete();
         done_q[k].delete();
      end
   endtask

   task automatic mon(int k, logic wr, logic rd, logic done, int addr, int data);
      wr_t e;
      int  d;
      if (wr) begin
         n_cmp++;
         if (rd) begin
            n_bad++;
            $display("FAIL overlap dut%0d cyc=%0d: read enable got 1 during write, need 0", k, cyc);
         end
         n_cmp++;
         if (exp_q[k].size() == 0) begin
            n_bad++;
            $display("FAIL extra_write dut%0d cyc=%0d: got addr=%0d data=%0d, need no write",
                     k, cyc, addr, data);
         end else begin
            e = exp_q[k].pop_front();
            if (e.cyc != cyc || e.addr != addr || e.data != data) begin
               n_bad++;
               $display("FAIL write dut%0d: got cyc=%0d addr=%0d data=%0d, need cyc=%0d addr=%0d data=%0d",
                        k, cyc, addr, data, e.cyc, e.addr, e.data);
            end
         end
      end
      if (done) begin
         n_cmp++;
         if (done_q[k].size() == 0) begin
            n_bad++;
            $display("FAIL extra_done dut%0d: got done at cyc=%0d, need none", k, cyc);
         end else begin
            d = done_q[k].pop_front();
            if (d != cyc) begin
               n_bad++;
               $display("FAIL done_cycle dut%0d: got cyc=%0d, need cyc=%0d", k, cyc, d);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus_r.out_wr_en, bus_r.in_rd_en | bus_r.w_rd_en | bus_r.b_rd_en,
          bus_r.input_compute_done, int'(bus_r.out_addr), int'(bus_r.out_data));
      mon(1, bus_n.out_wr_en, bus_n.in_rd_en | bus_n.w_rd_en | bus_n.b_rd_en,
          bus_n.input_compute_done, int'(bus_n.out_addr), int'(bus_n.out_data));
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_zero(string tag);
      logic [30:0] vr, vn;
      vr = {bus_r.input_compute_done, bus_r.busy, bus_r.in_rd_en, bus_r.in_addr, bus_r.w_rd_en,
            bus_r.w_addr, bus_r.b_rd_en, bus_r.b_addr, bus_r.out_wr_en, bus_r.out_addr,
            bus_r.out_data};
      vn = {bus_n.input_compute_done, bus_n.busy, bus_n.in_rd_en, bus_n.in_addr, bus_n.w_rd_en,
            bus_n.w_addr, bus_n.b_rd_en, bus_n.b_addr, bus_n.out_wr_en, bus_n.out_addr,
            bus_n.out_data};
      n_cmp++;
      if (vr != '0) begin
         n_bad++;
         $display("FAIL %s dut0: outputs got 0x%08h, need 0", tag, vr);
      end
      n_cmp++;
      if (vn != '0) begin
         n_bad++;
         $display("FAIL %s dut1: outputs got 0x%08h, need 0", tag, vn);
      end
   endtask

   task automatic start_run(output int s);
      tick();
      start = 1'b1;
      s = cyc;
      push_run(s);
      tick();
      start = 1'b0;
      n_cmp++;
      if (bus_r.busy !== 1'b1 || bus_n.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_after_start: got %b/%b, need 1/1", bus_r.busy, bus_n.busy);
      end
   endtask

   task automatic wait_idle(int limit);
      int t;
      t = 0;
      while ((done_q[0].size() != 0 || done_q[1].size() != 0) && t < limit) begin
         tick();
         t++;
      end
      if (done_q[0].size() != 0 || done_q[1].size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: got no done within %0d cycles, need done", limit);
         flush();
      end
      tick();
   endtask

   // 0: x=16 w=2 b=0 | 1: x=16 w=-2, neuron 3 w=0 b=5 | 2: x=127 w=127 | 3: x=-128 w=127
   // 4: full-range random | 5: small random
   task automatic fill(int mode);
      for (int i = 0; i < int'(N_IN); i++) begin
         case (mode)
            2:       x_mem[i] = 8'sd127;
            3:       x_mem[i] = 8'h80;
            4:       x_mem[i] = 8'($urandom);
            5:       x_mem[i] = 8'($urandom_range(0, 15)) - 8'd8;
            default: x_mem[i] = 8'sd16;
         endcase
      end
      for (int j = 0; j < int'(N_OUT); j++) begin
         case (mode)
            1:       b_mem[j] = (j == 3) ? 8'sd5 : 8'sd0;
            4:       b_mem[j] = 8'($urandom);
            5:       b_mem[j] = 8'($urandom_range(0, 63)) - 8'd32;
            default: b_mem[j] = 8'sd0;
         endcase
         for (int i = 0; i < int'(N_IN); i++) begin
            case (mode)
               0:       w_mem[j*N_IN + i] = 8'sd2;
               1:       w_mem[j*N_IN + i] = (j == 3) ? 8'sd0 : -8'sd2;
               4:       w_mem[j*N_IN + i] = 8'($urandom);
               5:       w_mem[j*N_IN + i] = 8'($urandom_range(0, 15)) - 8'd8;
               default: w_mem[j*N_IN + i] = 8'sd127;
            endcase
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      fill(0);

      // Reset held with start toggling
      for (int c = 0; c < 3; c++) begin
         tick();
         start = ~start;
         check_zero("reset_hold");
      end
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_zero("after_reset");

      // Directed patterns
      for (int m = 0; m < 4; m++) begin
         fill(m);
         start_run(s);
         wait_idle(RunCyc + 40);
      end

      // Start re-asserted mid-run must be ignored
      fill(0);
      start_run(s);
      while (cyc < s + 40) tick();
      start = 1'b1;
      repeat (10) tick();
      start = 1'b0;
      wait_idle(RunCyc + 40);

      // Start held high: second run sampled in the IDLE cycle after DONE
      fill(4);
      tick();
      start = 1'b1;
      s = cyc;
      push_run(s);
      push_run(s + RunCyc + 1);
      while (cyc < s + RunCyc + 2) tick();
      start = 1'b0;
      wait_idle(2 * RunCyc + 40);

      // Randomised runs
      for (int r = 0; r < 6; r++) begin
         fill((r % 2 == 0) ? 5 : 4);
         start_run(s);
         wait_idle(RunCyc + 40);
      end

      // Reset during neuron 3 MAC phase
      fill(5);
      start_run(s);
      while (cyc < s + 3 * NeuronCyc + 8) tick();
      n_cmp++;
      if (exp_q[0].size() != 5 || exp_q[1].size() != 5) begin
         n_bad++;
         $display("FAIL writes_before_reset: got %0d/%0d pending, need 5/5",
                  exp_q[0].size(), exp_q[1].size());
      end
      reset = 1'b0;
      #1;
      check_zero("mid_run_reset");
      flush();
      repeat (3) tick();
      reset = 1'b1;
      repeat (30) tick();
      start_run(s);
      wait_idle(RunCyc + 40);

      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (exp_q[k].size() != 0 || done_q[k].size() != 0) begin
            n_bad++;
            $display("FAIL leftover dut%0d: got %0d writes/%0d dones pending, need 0/0",
                     k, exp_q[k].size(), done_q[k].size());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
